imem_loader: RTL and testbench

Boot-time writer for the instruction RAM. It receives a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instructions. Each instruction is written to consecutive word-aligned addresses starting at 0x00. The loader holds the CPU core in reset until the program image is fully written. It sits between the host byte link (UART/debug bridge) and the write port of the instruction RAM; the fetch side continues to read through its 8-bit byte address.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_byte_packer.sv | 41 ++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned LANES         = 4;
    localparam int unsigned ADDR_SHIFT    = 2;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word/word_complete are valid
// in the cycle the lane-3 byte is pushed.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] lane;
    logic [7:0] lane_byte [3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane         <= 2'd0;
            lane_byte[0] <= 8'h00;
            lane_byte[1] <= 8'h00;
            lane_byte[2] <= 8'h00;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (push) begin
            unique case (lane)
                2'd0:    lane_byte[0] <= byte_in;
                2'd1:    lane_byte[1] <= byte_in;
                2'd2:    lane_byte[2] <= byte_in;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end

    // Lane 3 bypasses storage so the word is ready on the accepting edge.
    assign word          = {byte_in, lane_byte[2], lane_byte[1], lane_byte[0]};
    assign word_complete = push && (lane == 2'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: count byte, then 4*N data bytes packed into words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e           state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_idx;
    logic             accept;
    logic             push;
    logic             pack_clear;
    logic [31:0]      word;
    logic             word_complete;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // Once the last word has been issued, LOAD stops accepting while the write commits.
    assign in_ready   = (state == StIdle) || (state == StChk) ||
                        ((state == StLoad) && (word_idx != word_cnt));
    assign accept     = in_valid && in_ready;
    assign push       = accept && (state == StLoad);
    assign pack_clear = accept && (state == StIdle);

    imem_byte_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (pack_clear),
        .push          (push),
        .byte_in       (in_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            word_cnt <= '0;
            word_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if ((in_data != 8'h00) && (32'(in_data) <= DEPTH)) begin
                            word_cnt <= CNT_W'(in_data);
                            word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum     <= 8'h00;
`endif
                            state    <= StLoad;
                        end else begin
                            err   <= 1'b1;
                            state <= StErr;
                        end
                    end
                end
                StLoad: begin
                    if (word_complete) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= ADDR_W'(word_idx) << ADDR_SHIFT;
                        wr_data  <= word;
                        word_idx <= word_idx + 1'b1;
                    end else if (word_idx == word_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= StChk;
`else
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        state    <= StDone;
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (push) begin
                        csum <= csum ^ in_data;
                    end
`endif
                end
                StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        if (in_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= StDone;
                        end else begin
                            err   <= 1'b1;
                            state <= StErr;
                        end
                    end
`else
                    state <= StIdle;
`endif
                end
                StDone, StErr: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        wr_addr  <= '0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN if defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img [$];
    logic [7:0]  wa_q [$];
    logic [31:0] wd_q [$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    // Count byte, data bytes from img with optional idle gaps, then trailer if enabled.
    task automatic load_image(input int gap_max);
        logic [7:0] x = 8'h00;
        send_byte(8'(img.size() / 4));
        foreach (img[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            send_byte(img[i]);
            x ^= img[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!done && !err && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_end_reached"}, 32'(done | err), 32'd1);
    endtask

    task automatic check_image_writes(input string tag);
        int nw = img.size() / 4;
        check({tag, "_wr_count"}, 32'(wa_q.size()), 32'(nw));
        for (int k = 0; k < nw && k < wa_q.size(); k++) begin
            check({tag, "_wr_addr"}, 32'(wa_q[k]), 32'(4 * k));
            check({tag, "_wr_data"}, wd_q[k],
                  {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]});
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single word, back-to-back
        img = '{8'h33, 8'h70, 8'h00, 8'h00};
        load_image(0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_wr_addr", 32'(wr_addr), 32'h00);
        check("t1_wr_data", wr_data, 32'h0000_7033);
        check("t1_done_early", 32'(done), 32'd0);
        tick();
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check_image_writes("t1");

        // Three words with random gaps
        pulse_start();
        check("t2_restart_done", 32'(done), 32'd0);
        check("t2_restart_hold", 32'(cpu_hold), 32'd1);
        check("t2_restart_addr", 32'(wr_addr), 32'd0);
        check("t2_restart_ready", 32'(in_ready), 32'd1);
        clear_writes();
        img = '{8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                8'h13, 8'h01, 8'h20, 8'h00};
        load_image(3);
        wait_end("t2");
        check("t2_done", 32'(done), 32'd1);
        check_image_writes("t2");

        // Illegal counts 0x00 and 0x41
        pulse_start();
        clear_writes();
        send_byte(8'h00);
        check("t3a_err", 32'(err), 32'd1);
        check("t3a_in_ready", 32'(in_ready), 32'd0);
        check("t3a_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3a_done", 32'(done), 32'd0);
        pulse_start();
        check("t3a_clr_err", 32'(err), 32'd0);
        check("t3a_clr_ready", 32'(in_ready), 32'd1);
        send_byte(8'h41);
        repeat (3) tick();
        check("t3b_err", 32'(err), 32'd1);
        check("t3b_in_ready", 32'(in_ready), 32'd0);
        check("t3b_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3_no_writes", 32'(wa_q.size()), 32'd0);
        pulse_start();
        check("t3b_clr_err", 32'(err), 32'd0);

        // Full 64-word image
        clear_writes();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(8'(i * 7 + 1));
        load_image(0);
        wait_end("t4");
        check("t4_done", 32'(done), 32'd1);
        check("t4_last_addr", 32'(wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 8'h00), 32'hFC);
        check_image_writes("t4");

        // Reset mid-load, then a fresh single-word load
        pulse_start();
        clear_writes();
        send_byte(8'h02);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_byte(8'hA5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en", 32'(wr_en), 32'd0);
        check("t5_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("t5_rst_wr_data", wr_data, 32'd0);
        check("t5_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_in_ready", 32'(in_ready), 32'd1);
        clear_writes();
        img = '{8'h78, 8'h56, 8'h34, 8'h12};
        load_image(0);
        wait_end("t5");
        check("t5_done", 32'(done), 32'd1);
        check_image_writes("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad trailer
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h33);
        send_byte(8'h70);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        tick();
        check("t6_err", 32'(err), 32'd1);
        check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t6_done", 32'(done), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
